// File: rtl/mult_seq_shift_add.sv
// Iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH, unsigned or two's complement per transaction.
// Latency: WIDTH cycles from operand transfer to out_valid; one result per WIDTH+2 cycles at best.
// Backpressure: result held in DONE until out_ready; in_ready low (operands ignored) while RUN/DONE.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake carrying a, b, is_signed
//   out_valid / out_ready result handshake carrying product
//   busy                  high while an operation is in progress or its result is waiting
module mult_seq_shift_add #(
    parameter int WIDTH     = 8,
    parameter int SIGNED_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int CNT_W   = $clog2(WIDTH);
    localparam bit HAS_SGN = (SIGNED_EN != 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic [WIDTH:0]     mcand;     // multiplicand, extended by one bit
    logic [WIDTH-1:0]   mplier;    // multiplier, consumed LSB first
    logic [2*WIDTH:0]   acc;       // running partial product
    logic [CNT_W-1:0]   cnt;
    logic               sgn;

    logic               sgn_in;
    logic               last;
    logic [WIDTH:0]     upper;
    logic [WIDTH:0]     addend;
    logic [WIDTH:0]     sum;
    logic               fill;
    logic [2*WIDTH:0]   acc_nxt;

    // With signed mode compiled out, is_signed has no effect and sgn stays 0.
    assign sgn_in = HAS_SGN & is_signed;

    assign last   = (cnt == CNT_W'(WIDTH - 1));
    assign upper  = acc[2*WIDTH:WIDTH];
    assign addend = mplier[0] ? mcand : '0;

    // The multiplier MSB carries negative weight in two's complement, so the
    // final iteration subtracts the multiplicand instead of adding it.
    generate
        if (HAS_SGN) begin : g_addsub
            assign sum = (sgn && last) ? (upper - addend) : (upper + addend);
        end else begin : g_add
            assign sum = upper + addend;
        end
    endgenerate

    // In unsigned mode sum[WIDTH] is a carry, not a sign, so the shift fills with 0.
    assign fill    = sgn & sum[WIDTH];
    assign acc_nxt = {fill, sum, acc[WIDTH-1:1]};

    // rst gates in_ready so it reads 0 for the whole reset pulse, not just after the first edge.
    assign in_ready  = (state == S_IDLE) && !rst;
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            sgn     <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        mcand  <= {sgn_in & a[WIDTH-1], a};
                        mplier <= b;
                        sgn    <= sgn_in;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc    <= acc_nxt;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (last) begin
                        product <= acc_nxt[2*WIDTH-1:0];
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_shift_add.sv
// Bench for mult_seq_shift_add: three instances (8-bit signed-capable, 4-bit signed-capable,
// 4-bit unsigned-only) checked against an arithmetic reference model.
module tb_mult_seq_shift_add;

    logic clk = 1'b0;
    logic rst;

    logic       iv [3];
    logic       ordy [3];
    logic       sg [3];
    logic       irdy [3];
    logic       ovld [3];
    logic       bsy [3];
    logic [7:0] a0, b0;
    logic [3:0] a1, b1, a2, b2;
    logic [15:0] prod0;
    logic [7:0]  prod1, prod2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mult_seq_shift_add #(.WIDTH(8), .SIGNED_EN(1)) u_m8 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .a(a0), .b(b0),
        .is_signed(sg[0]), .out_valid(ovld[0]), .out_ready(ordy[0]), .product(prod0), .busy(bsy[0])
    );

    mult_seq_shift_add #(.WIDTH(4), .SIGNED_EN(1)) u_m4s (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .a(a1), .b(b1),
        .is_signed(sg[1]), .out_valid(ovld[1]), .out_ready(ordy[1]), .product(prod1), .busy(bsy[1])
    );

    mult_seq_shift_add #(.WIDTH(4), .SIGNED_EN(0)) u_m4u (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]), .a(a2), .b(b2),
        .is_signed(sg[2]), .out_valid(ovld[2]), .out_ready(ordy[2]), .product(prod2), .busy(bsy[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer multiplication of the operands interpreted per mode.
    function automatic logic [31:0] ref_mult(input int w, input bit se, input bit s,
                                             input logic [7:0] x, input logic [7:0] y);
        longint xv, yv, p, m1, m2;
        m1 = (longint'(1) << w) - 1;
        m2 = (longint'(1) << (2 * w)) - 1;
        xv = longint'(x) & m1;
        yv = longint'(y) & m1;
        if (se && s) begin
            if (xv >= (longint'(1) << (w - 1))) xv = xv - (longint'(1) << w);
            if (yv >= (longint'(1) << (w - 1))) yv = yv - (longint'(1) << w);
        end
        p = (xv * yv) & m2;
        return p[31:0];
    endfunction

    function automatic int w_of(input int d);
        return (d == 0) ? 8 : 4;
    endfunction

    function automatic logic [31:0] get_prod(input int d);
        case (d)
            0:       return {16'h0, prod0};
            1:       return {24'h0, prod1};
            default: return {24'h0, prod2};
        endcase
    endfunction

    task automatic set_in(input int d, input logic v, input logic [7:0] x, input logic [7:0] y,
                          input logic s);
        iv[d] = v;
        sg[d] = s;
        case (d)
            0:       begin a0 = x;      b0 = y;      end
            1:       begin a1 = x[3:0]; b1 = y[3:0]; end
            default: begin a2 = x[3:0]; b2 = y[3:0]; end
        endcase
    endtask

    // One transaction; called at a negedge. hold = cycles out_ready stays low after out_valid.
    // low_cnt returns how many sampled cycles in_ready was low from the transfer until retire.
    task automatic do_txn(input int d, input logic [7:0] x, input logic [7:0] y, input logic s,
                          input int hold, input logic [31:0] exp, output int low_cnt);
        int k;
        int lat;
        logic [31:0] res;
        ordy[d] = (hold == 0);
        set_in(d, 1'b1, x, y, s);
        k = 0;
        while (!irdy[d] && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_eq("accept", {31'h0, irdy[d]}, 32'd1);
        @(negedge clk);
        set_in(d, 1'b0, x, y, s);
        low_cnt = irdy[d] ? 0 : 1;
        lat = 0;
        while (!ovld[d] && lat < 100) begin
            @(negedge clk);
            lat++;
            if (!irdy[d]) low_cnt++;
        end
        check_eq("latency", lat, w_of(d));
        check_eq("busy_done", {31'h0, bsy[d]}, 32'd1);
        res = get_prod(d);
        check_eq("product", res, exp);
        for (int i = 0; i < hold; i++) begin
            if (i == hold / 2) set_in(d, 1'b1, ~x, ~y, s);
            @(negedge clk);
            set_in(d, 1'b0, x, y, s);
            if (!irdy[d]) low_cnt++;
            check_eq("hold_product", get_prod(d), res);
            check_eq("hold_valid", {31'h0, ovld[d]}, 32'd1);
            check_eq("hold_in_ready", {31'h0, irdy[d]}, 32'd0);
        end
        ordy[d] = 1'b1;
        @(negedge clk);
        check_eq("retired_valid", {31'h0, ovld[d]}, 32'd0);
        check_eq("retired_ready", {31'h0, irdy[d]}, 32'd1);
        check_eq("product_kept", get_prod(d), res);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lc;
        int cyc, last_cyc, idx, done_cnt;
        bit stayed_low;
        logic [31:0] exp_q[$];
        logic [8:0]  p;
        logic [7:0]  rx, ry;
        logic        rs;
        int          rh;

        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b0; sg[d] = 1'b0;
        end
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;

        // Reset state
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check_eq("rst_in_ready", {31'h0, irdy[d]}, 32'd0);
            check_eq("rst_out_valid", {31'h0, ovld[d]}, 32'd0);
            check_eq("rst_busy", {31'h0, bsy[d]}, 32'd0);
            check_eq("rst_product", get_prod(d), 32'd0);
        end
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) check_eq("post_rst_in_ready", {31'h0, irdy[d]}, 32'd1);
        @(negedge clk);

        // Unsigned corner: 255*255, in_ready low for WIDTH+1 cycles
        do_txn(0, 8'd255, 8'd255, 1'b0, 0, 32'hFE01, lc);
        check_eq("in_ready_low_cycles", lc, 9);

        // Signed corners
        do_txn(0, 8'h80, 8'h80, 1'b1, 0, 32'h4000, lc);
        do_txn(0, 8'hFF, 8'h7F, 1'b1, 0, 32'hFF81, lc);
        do_txn(0, 8'h80, 8'h01, 1'b1, 0, 32'hFF80, lc);

        // Backpressure with an ignored in_valid pulse, then no spurious second result
        do_txn(0, 8'd13, 8'd11, 1'b0, 5, 32'd143, lc);
        stayed_low = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ovld[0] || !irdy[0]) stayed_low = 1'b0;
        end
        check_eq("no_second_result", {31'h0, stayed_low}, 32'd1);

        // Reset during iteration 3
        ordy[0] = 1'b1;
        set_in(0, 1'b1, 8'd200, 8'd100, 1'b0);
        @(negedge clk);
        set_in(0, 1'b0, 8'd200, 8'd100, 1'b0);
        check_eq("midrst_busy_before", {31'h0, bsy[0]}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_in_ready", {31'h0, irdy[0]}, 32'd0);
        check_eq("midrst_out_valid", {31'h0, ovld[0]}, 32'd0);
        check_eq("midrst_busy", {31'h0, bsy[0]}, 32'd0);
        check_eq("midrst_product", get_prod(0), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("midrst_ready_after", {31'h0, irdy[0]}, 32'd1);
        @(negedge clk);
        stayed_low = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (ovld[0]) stayed_low = 1'b0;
            @(negedge clk);
        end
        check_eq("midrst_no_valid", {31'h0, stayed_low}, 32'd1);
        do_txn(0, 8'd3, 8'd5, 1'b0, 0, 32'd15, lc);

        // Randomized transactions with random backpressure
        for (int i = 0; i < 40; i++) begin
            rx = 8'($urandom_range(0, 255));
            ry = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            rh = $urandom_range(0, 3);
            do_txn(0, rx, ry, rs, rh, ref_mult(8, 1'b1, rs, rx, ry), lc);
        end

        // Exhaustive 4-bit, both modes, back-to-back
        ordy[1] = 1'b1;
        idx = 0; done_cnt = 0; cyc = 0; last_cyc = 0;
        p = 9'd0;
        set_in(1, 1'b1, {4'h0, p[7:4]}, {4'h0, p[3:0]}, p[8]);
        while (done_cnt < 512 && cyc < 5000) begin
            if (ovld[1]) begin
                if (exp_q.size() == 0) begin
                    check_eq("exh_extra_result", 32'd1, 32'd0);
                end else begin
                    check_eq("exh_product", get_prod(1), exp_q.pop_front());
                end
                done_cnt++;
            end
            if (irdy[1]) begin
                if (idx < 512) begin
                    p = idx[8:0];
                    exp_q.push_back(ref_mult(4, 1'b1, p[8], {4'h0, p[7:4]}, {4'h0, p[3:0]}));
                    if (idx > 0) check_eq("exh_spacing", cyc - last_cyc, 6);
                    last_cyc = cyc;
                    idx++;
                end
            end else begin
                p = idx[8:0];
                set_in(1, idx < 512, {4'h0, p[7:4]}, {4'h0, p[3:0]}, p[8]);
            end
            @(negedge clk);
            cyc++;
        end
        check_eq("exh_count", done_cnt, 512);

        // Signed mode compiled out: is_signed ignored
        do_txn(2, 8'h0F, 8'h0F, 1'b1, 0, 32'hE1, lc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
